// File: rtl/alu8_seq_sched_if.sv
// Bundle of request, response and ALU-side signals for alu8_seq_sched.
// master = sequencer side, slave = requesters / consumer / ALU side.
interface alu8_seq_sched_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_cout;
  logic         rsp_g;
  logic         rsp_e;

  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [2:0]   alu_s;
  logic [7:0]   alu_out;
  logic         alu_cout;
  logic         alu_g;
  logic         alu_e;

  logic         busy;

  modport master (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_g, rsp_e,
    input  rsp_ready,
    output alu_a, alu_b, alu_cin, alu_s,
    input  alu_out, alu_cout, alu_g, alu_e,
    output busy
  );

  modport slave (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_g, rsp_e,
    output rsp_ready,
    input  alu_a, alu_b, alu_cin, alu_s,
    output alu_out, alu_cout, alu_g, alu_e,
    input  busy
  );
endinterface

// File: rtl/alu8_seq_sched.sv
// Two-port arbiter and LSB-first byte sequencer for the shared 8-bit ALU.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed req0-first priority (default: round-robin).
module alu8_seq_sched #(
  parameter int NBYTES = 4
) (
  input logic              clk,
  input logic              rst,
  alu8_seq_sched_if.master bus
);
  localparam int             IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0]  LAST   = IW'(NBYTES - 1);
  localparam logic [2:0]     OP_ADD = 3'b010;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state, state_nx;
  logic [2:0]              op_r;
  logic [NBYTES-1:0][7:0]  a_r, b_r, res_r;
  logic                    id_r;
  logic [IW-1:0]           idx;
  logic                    carry, g_acc, e_acc;

  logic                    prefer0, grant0, grant1;
  logic                    accept, acc_id;
  logic                    ready0, ready1;
  logic [7:0]              alu_a_c, alu_b_c;
  logic                    alu_cin_c;
  logic [2:0]              alu_s_c;

  // Magnitude from LSB upward: a higher byte that differs overrides lower history.
  function automatic logic merge_g(input logic g_byte, input logic e_byte, input logic g_prev);
    return g_byte | (e_byte & g_prev);
  endfunction

`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign prefer0 = 1'b1;
`else
  logic last_id;

  // last_id resets to 1 so that req0 wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_id <= 1'b1;
    else if (accept) last_id <= acc_id;
  end

  assign prefer0 = last_id;
`endif

  assign grant0 = bus.req0_valid & (~bus.req1_valid | prefer0);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~prefer0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    accept    = 1'b0;
    acc_id    = 1'b0;
    alu_a_c   = 8'h00;
    alu_b_c   = 8'h00;
    alu_cin_c = 1'b0;
    alu_s_c   = 3'b000;
    case (state)
      IDLE: begin
        ready0 = grant0 & ~rst;
        ready1 = grant1 & ~rst;
        accept = (grant0 | grant1) & ~rst;
        acc_id = grant1;
        if (accept) state_nx = EXEC;
      end
      EXEC: begin
        alu_a_c   = a_r[idx];
        alu_b_c   = b_r[idx];
        alu_s_c   = op_r;
        alu_cin_c = (op_r == OP_ADD) & carry;
        if (idx == LAST) state_nx = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture at accept, then one result byte and flag update per EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= 3'b000;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      id_r  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      g_acc <= 1'b0;
      e_acc <= 1'b0;
    end else if (accept) begin
      op_r  <= acc_id ? bus.req1_op : bus.req0_op;
      a_r   <= acc_id ? bus.req1_a  : bus.req0_a;
      b_r   <= acc_id ? bus.req1_b  : bus.req0_b;
      res_r <= '0;
      id_r  <= acc_id;
      idx   <= '0;
      carry <= 1'b0;
      g_acc <= 1'b0;
      e_acc <= 1'b1;
    end else if (state == EXEC) begin
      res_r[idx] <= bus.alu_out;
      carry      <= (op_r == OP_ADD) & bus.alu_cout;
      g_acc      <= merge_g(bus.alu_g, bus.alu_e, g_acc);
      e_acc      <= e_acc & bus.alu_e;
      idx        <= idx + 1'b1;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_r;
  assign bus.rsp_data   = res_r;
  assign bus.rsp_cout   = carry;
  assign bus.rsp_g      = g_acc;
  assign bus.rsp_e      = e_acc;
  assign bus.alu_a      = alu_a_c;
  assign bus.alu_b      = alu_b_c;
  assign bus.alu_cin    = alu_cin_c;
  assign bus.alu_s      = alu_s_c;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu8_seq_sched.sv
// Bench for alu8_seq_sched: behavioural ALU, full-width result model with
// per-cycle response checking, and directed vectors with literal expectations.
module tb_alu8_seq_sched;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;
  localparam logic [2:0] OP_BUF_A = 3'd0, OP_NOT_A = 3'd1, OP_ADD = 3'd2, OP_OR = 3'd3,
                         OP_AND = 3'd4, OP_NOT_B = 3'd5, OP_BUF_B = 3'd6, OP_LOW = 3'd7;

  typedef struct {
    bit           id;
    logic [W-1:0] data;
    bit           cout;
    bit           g;
    bit           e;
    int           acc;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t expq[$];
  bit   glog[$];
  bit   prev_v = 0;
  logic [8:0] alu_sum;

  alu8_seq_sched_if #(.NBYTES(NBYTES)) bus();
  alu8_seq_sched #(.NBYTES(NBYTES)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-wide ALU the sequencer drives.
  always_comb begin
    alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};
    case (bus.alu_s)
      OP_BUF_A: bus.alu_out = bus.alu_a;
      OP_NOT_A: bus.alu_out = ~bus.alu_a;
      OP_ADD:   bus.alu_out = alu_sum[7:0];
      OP_OR:    bus.alu_out = bus.alu_a | bus.alu_b;
      OP_AND:   bus.alu_out = bus.alu_a & bus.alu_b;
      OP_NOT_B: bus.alu_out = ~bus.alu_b;
      OP_BUF_B: bus.alu_out = bus.alu_b;
      default:  bus.alu_out = 8'h00;
    endcase
    bus.alu_cout = (bus.alu_s == OP_ADD) ? alu_sum[8] : 1'b0;
    bus.alu_g    = bus.alu_a > bus.alu_b;
    bus.alu_e    = bus.alu_a == bus.alu_b;
  end

  function automatic exp_t model(input bit id, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t       r;
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_BUF_A: r.data = a;
      OP_NOT_A: r.data = ~a;
      OP_ADD:   r.data = sum[W-1:0];
      OP_OR:    r.data = a | b;
      OP_AND:   r.data = a & b;
      OP_NOT_B: r.data = ~b;
      OP_BUF_B: r.data = b;
      default:  r.data = '0;
    endcase
    r.id   = id;
    r.cout = (op == OP_ADD) ? sum[W] : 1'b0;
    r.g    = a > b;
    r.e    = a == b;
    r.acc  = acc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accept / response-handshake monitor: builds the expected-response queue.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      expq.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready && expq.size() > 0) void'(expq.pop_front());
      if (bus.req0_valid && bus.req0_ready) begin
        expq.push_back(model(1'b0, bus.req0_op, bus.req0_a, bus.req0_b, cyc));
        glog.push_back(1'b0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        expq.push_back(model(1'b1, bus.req1_op, bus.req1_a, bus.req1_b, cyc));
        glog.push_back(1'b1);
      end
    end
  end

  // Per-cycle comparison of the response port against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.busy) chk("ready_while_busy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      if (bus.rsp_valid) begin
        if (expq.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          chk("rsp_id",   {63'd0, bus.rsp_id},   {63'd0, expq[0].id});
          chk("rsp_data", {32'd0, bus.rsp_data}, {32'd0, expq[0].data});
          chk("rsp_cout", {63'd0, bus.rsp_cout}, {63'd0, expq[0].cout});
          chk("rsp_g",    {63'd0, bus.rsp_g},    {63'd0, expq[0].g});
          chk("rsp_e",    {63'd0, bus.rsp_e},    {63'd0, expq[0].e});
          if (!prev_v) chk("rsp_latency", 64'(cyc - expq[0].acc), 64'(NBYTES));
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic issue(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((id && bus.req1_ready) || (!id && bus.req0_ready)) begin
        ok = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("rsp_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_one(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input bit ec, input bit eg, input bit ee);
    issue(id, op, a, b);
    wait_rsp();
    chk("lit_id",   {63'd0, bus.rsp_id},   {63'd0, id});
    chk("lit_data", {32'd0, bus.rsp_data}, {32'd0, ed});
    chk("lit_cout", {63'd0, bus.rsp_cout}, {63'd0, ec});
    chk("lit_g",    {63'd0, bus.rsp_g},    {63'd0, eg});
    chk("lit_e",    {63'd0, bus.rsp_e},    {63'd0, ee});
    @(negedge clk);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy && expq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [W-1:0] snap;
    logic [1:0]   exp_rdy;
    bit           ok;
    bit           exp_g [4];

    rst = 1'b1;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = OP_ADD; bus.req1_a = '0; bus.req1_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_busy",      {63'd0, bus.busy},      64'd0);
    chk("rst_rsp_data",  {32'd0, bus.rsp_data},  64'd0);
    chk("rst_rsp_flags", {60'd0, bus.rsp_id, bus.rsp_cout, bus.rsp_g, bus.rsp_e}, 64'd0);
    chk("rst_alu",       {44'd0, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s}, 64'd0);
    chk("rst_ready",     {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;

    run_one(1'b0, OP_ADD,   32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b1, 1'b0);
    run_one(1'b1, OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_one(1'b0, OP_OR,    32'h01000000, 32'h00FFFFFF, 32'h01FFFFFF, 1'b0, 1'b1, 1'b0);
    run_one(1'b1, OP_AND,   32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1);
    run_one(1'b0, OP_LOW,   32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run_one(1'b1, OP_NOT_B, 32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0);
    run_one(1'b0, OP_BUF_B, 32'h010000FF, 32'h02000000, 32'h02000000, 1'b0, 1'b0, 1'b0);
    run_one(1'b1, OP_NOT_A, 32'h00FF00FF, 32'h00FF00FE, 32'hFF00FF00, 1'b0, 1'b1, 1'b0);
    run_one(1'b0, OP_BUF_A, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0);

    // Back-pressure: response held in RESP while both requesters wait.
    bus.rsp_ready = 1'b0;
    issue(1'b0, OP_ADD, 32'h00000005, 32'h00000007);
    wait_rsp();
    snap = bus.rsp_data;
    chk("hold_lit_data", {32'd0, snap}, 64'h0000000C);
    bus.req0_valid = 1'b1; bus.req0_op = OP_OR; bus.req0_a = 32'h1; bus.req0_b = 32'h2;
    bus.req1_valid = 1'b1; bus.req1_op = OP_OR; bus.req1_a = 32'h4; bus.req1_b = 32'h8;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_busy",  {63'd0, bus.busy},      64'd1);
      chk("hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("hold_data",  {32'd0, bus.rsp_data},  {32'd0, snap});
      chk("hold_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_busy",  {63'd0, bus.busy},      64'd0);
    chk("hold_release_valid", {63'd0, bus.rsp_valid}, 64'd0);
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_rdy = 2'b01;
`else
    exp_rdy = 2'b10;
`endif
    chk("hold_release_ready", {62'd0, bus.req1_ready, bus.req0_ready}, {62'd0, exp_rdy});
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();

    // Abort during EXEC byte 2 of a req0 operation.
    issue(1'b0, OP_ADD, 32'h44332211, 32'h01010101);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("exec_b2_alu_a", {56'd0, bus.alu_a}, 64'h33);
    chk("exec_b2_alu_b", {56'd0, bus.alu_b}, 64'h01);
    chk("exec_b2_alu_s", {61'd0, bus.alu_s}, 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy",  {63'd0, bus.busy},      64'd0);
    chk("abort_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("abort_rsp",   {28'd0, bus.rsp_data, bus.rsp_id, bus.rsp_cout, bus.rsp_g, bus.rsp_e}, 64'd0);
    chk("abort_alu",   {44'd0, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s}, 64'd0);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'h1;  bus.req0_b = 32'h2;
    bus.req1_valid = 1'b1; bus.req1_op = OP_OR;  bus.req1_a = 32'h10; bus.req1_b = 32'h01;
    #1;
    chk("rst_hold_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    glog.delete();
    @(negedge clk);
    rst = 1'b0;

    // Both requesters continuously valid.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (glog.size() >= 4) begin ok = 1'b1; break; end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (!ok) chk("grant_timeout", 64'd1, 64'd0);
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) chk($sformatf("grant%0d", i), {63'd0, glog[i]}, {63'd0, exp_g[i]});
      else                 chk($sformatf("grant%0d_missing", i), 64'd1, 64'd0);
    end
    drain();
    chk("queue_empty", 64'(expq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu8_seq_sched.md
# alu8_seq_sched

Multi-byte sequencer and two-port arbiter for the shared 8-bit ALU datapath (ops BUF_A, NOT_A, ADD, OR, AND, NOT_B, BUF_B, LOW; flags cout/g/e). It accepts NBYTES-wide operations from two requesters and grants one at a time. It drives the ALU one byte per cycle, LSB first, chaining carry and accumulating magnitude/equality flags. It returns a full-width result on a valid/ready response port.

## Interface
- NBYTES, 4, operand width in bytes (W = 8*NBYTES), legal 1..8
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- reqN_valid (N=0,1)  in  1  request pending
- reqN_ready  out  1  request accepted this cycle when valid&ready
- reqN_op  in  3  ALU select code (000..111, same encoding as ALU S)
- reqN_a, reqN_b  in  W  operands
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_data  out  W  result
- rsp_cout, rsp_g, rsp_e  out  1  final carry, A>B, A==B (unsigned, full width)
- alu_a, alu_b  out  8  byte operands to ALU
- alu_cin  out  1  carry into ALU
- alu_s  out  3  ALU select
- alu_out  in  8  ALU result (combinational)
- alu_cout, alu_g, alu_e  in  1  ALU flags
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: reqN_ready combinational, high only for the granted requester while reqN_valid; the other ready is 0. On accept, latch op/a/b/id, clear byte index, set carry=0, g_acc=0, e_acc=1, go EXEC.
- Arbitration: round-robin. When one requester is valid, it wins. When both are valid, the one not granted last wins. The pointer updates only on accept.
- EXEC, byte i: alu_a=a[8i+7:8i], alu_b=b[8i+7:8i], alu_s=op. alu_cin = carry when op=ADD, else 0. At edge: result[8i+7:8i]=alu_out. carry=alu_cout for ADD, else 0. g_acc = alu_g | (alu_e & g_acc). e_acc = e_acc & alu_e. After i=NBYTES-1, go RESP.
- RESP: rsp_valid=1; rsp_data/cout/g/e/id stable. On rsp_valid&rsp_ready, return to IDLE. No request is accepted in the same cycle.
- rsp_cout = carry out of the MSB byte for ADD, 0 for other ops. g/e are valid for every op.
- Outside EXEC: alu_a=alu_b=0, alu_cin=0, alu_s=000.

## Timing
- Accept at edge k. EXEC occupies cycles k..k+NBYTES-1. rsp_valid rises after edge k+NBYTES. Latency = NBYTES cycles.
- Minimum issue interval = NBYTES+2 cycles (EXEC + 1 RESP cycle + 1 IDLE cycle).
- rsp_ready low holds RESP indefinitely. All rsp_* stay stable and both reqN_ready stay 0.
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_cout/g/e 0, busy 0, alu_* 0, reqN_ready 0 while rst high. The RR pointer favours req0 first.
- rst asserted mid-EXEC or mid-RESP: immediate abort, outputs to reset values, the in-flight operation is discarded, and no response is issued.
- Requester inputs are sampled only at accept. Changes afterward are ignored.

## Configuration
- ALU_SCHED_FIXED_PRIO_EN defined: fixed priority. req0 always wins when both are valid, and the RR pointer is removed.
- Undefined (default): round-robin arbitration as above.

## Test plan
- NBYTES=4, req0 ADD a=0x000000FF b=0x00000001 -> rsp_data=0x00000100, rsp_cout=0, rsp_g=1, rsp_e=0, rsp_id=0, rsp_valid 4 cycles after accept.
- ADD a=0xFFFFFFFF b=0x00000001 -> rsp_data=0x00000000, rsp_cout=1, rsp_g=1. Op OR a=0x01000000 b=0x00FFFFFF -> 0x01FFFFFF, g=1, e=0, cout=0.
- Op AND a=b=0x12345678 -> data 0x12345678, e=1, g=0. Op LOW -> data 0, e=1. Op NOT_B b=0x0F0F0F0F -> 0xF0F0F0F0.
- Both requesters valid continuously, rsp_ready=1 -> grants 0,1,0,1. With ALU_SCHED_FIXED_PRIO_EN -> 0,0,0,0.
- rsp_ready low 10 cycles in RESP -> rsp_* unchanged, reqN_ready=0, busy=1. Raising rsp_ready -> IDLE next cycle.
- rst pulsed during EXEC byte 2 -> all outputs 0 immediately, no rsp_valid. With both valid after release, first grant goes to req0.
